// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DEFAULT_MAX_BURST = 4;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start,
// wrapping modulo NUM_REQ.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] start,
  output logic                 any_valid,
  output logic [IDX_WIDTH-1:0] winner
);

  // Scan from start upward and keep the first hit.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    any_valid = 1'b0;
    winner    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(start) + i) % NUM_REQ;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = IDX_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ requesters,
// with bounded bursts and combinational back-pressure on fifo_full.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_BURST     = DEFAULT_MAX_BURST,
  parameter int unsigned REQ_IDX_WIDTH = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [REQ_IDX_WIDTH-1:0]      grant_id
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef logic [REQ_IDX_WIDTH-1:0] idx_t;

  arb_state_e       state, state_next;
  idx_t             grant_q, grant_next;
  idx_t             rr_ptr, rr_next;
  idx_t             winner, rr_after;
  logic [CNT_W-1:0] beat_cnt, cnt_next;
  logic             any_valid;
  logic             holder_valid;
  logic             fire;
  logic             last_beat;
  logic             burst_end;

  fifo_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_pick (
    .req       (req_valid),
    .start     (rr_ptr),
    .any_valid (any_valid),
    .winner    (winner)
  );

  assign rr_after = (winner == idx_t'(NUM_REQ - 1)) ? '0 : winner + idx_t'(1);

  // Holder status: its valid, whether it fires, and whether the burst ends here.
  always_comb begin
    holder_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == idx_t'(i)) holder_valid = req_valid[i];
    end
    fire      = (state == BURST) && !fifo_full && holder_valid;
    last_beat = fire && (beat_cnt == CNT_W'(MAX_BURST - 1));
    burst_end = (state == BURST) && (!holder_valid || last_beat);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state plus grant/pointer/beat updates; a finished burst re-arbitrates
  // in the same edge so waiting requesters see no dead cycle.
  always_comb begin
    state_next = state;
    grant_next = grant_q;
    rr_next    = rr_ptr;
    cnt_next   = beat_cnt;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = BURST;
          grant_next = winner;
          rr_next    = rr_after;
          cnt_next   = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          cnt_next = '0;
          if (any_valid) begin
            grant_next = winner;
            rr_next    = rr_after;
          end else begin
            state_next = IDLE;
          end
        end else if (fire) begin
          cnt_next = beat_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant, round-robin pointer and beat counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      grant_q  <= grant_next;
      rr_ptr   <= rr_next;
      beat_cnt <= cnt_next;
    end
  end

  // Outputs: ready/push/data are combinational so fifo_full gates them in-cycle.
  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    grant_valid  = (state == BURST);
    grant_id     = grant_q;
    fifo_push    = fire;
    if (state == BURST) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_q == idx_t'(i)) begin
          req_ready[i] = !fifo_full;
          fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule
